// File: rtl/reg_bank_arbiter_if.sv
// Requester and register-bank side signals of reg_bank_arbiter.
// The master modport is the requesters plus the bank; slave is the arbiter.
interface reg_bank_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int REG_W   = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        wr;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*REG_W-1:0]  wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        err;
  logic [REG_W-1:0]          rdata;
  logic                      bank_we;
  logic [ADDR_W-1:0]         bank_addr;
  logic [REG_W-1:0]          bank_wdata;
  logic [REG_W-1:0]          bank_rdata;

  modport master (
    output req, wr, addr, wdata, bank_rdata,
    input  ack, err, rdata, bank_we, bank_addr, bank_wdata
  );

  modport slave (
    input  req, wr, addr, wdata, bank_rdata,
    output ack, err, rdata, bank_we, bank_addr, bank_wdata
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Shares one register-bank port between NUM_REQ requesters: grant, one-cycle access, ack.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module reg_bank_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int REG_W   = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  output logic busy,
  reg_bank_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic [IDX_W-1:0]    lat_idx;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_addr;
  logic [REG_W-1:0]    lat_wdata;
  logic                drop;
`ifndef REG_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]    last_winner;
`endif

  // First set request, scanning upward from the slot after the previous winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      logic [IDX_W-1:0] cidx;
`ifdef REG_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(last_winner) + 1 + k) % NUM_REQ;
`endif
      cidx = IDX_W'(cand);
      if (!win_vld && bus.req[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ena && win_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lat_idx   <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      drop      <= 1'b0;
      bus.ack   <= '0;
      bus.err   <= '0;
      bus.rdata <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
      last_winner <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      bus.ack <= '0;
      bus.err <= '0;
      case (state)
        IDLE: if (ena && win_vld) begin
          lat_idx   <= win_idx;
          lat_wr    <= bus.wr[win_idx];
          lat_addr  <= bus.addr[int'(win_idx)*ADDR_W +: ADDR_W];
          lat_wdata <= bus.wdata[int'(win_idx)*REG_W +: REG_W];
        end
        // A write that saw ena low in its access cycle was dropped; it gets no err.
        ACCESS: drop <= !ena;
        RESP: begin
          bus.ack <= NUM_REQ'(1) << lat_idx;
          if (lat_wr && lat_addr[ADDR_W-1] && !drop)
            bus.err <= NUM_REQ'(1) << lat_idx;
          if (!lat_wr)
            bus.rdata <= bus.bank_rdata;
`ifndef REG_ARB_FIXED_PRIO_EN
          last_winner <= lat_idx;
`endif
        end
        default: ;
      endcase
    end
  end

  // Latched address/data hold between accesses; the strobe is only ever in ACCESS.
  assign bus.bank_addr  = lat_addr;
  assign bus.bank_wdata = lat_wdata;
  assign bus.bank_we    = (state == ACCESS) && lat_wr && !lat_addr[ADDR_W-1] && ena;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed checks of reg_bank_arbiter: write, read, status write, contention, ena, reset.
module tb_reg_bank_arbiter;
  logic clk = 1'b0;
  logic rstb;
  logic ena;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  reg_bank_arbiter_if #(.NUM_REQ(2), .ADDR_W(4), .REG_W(8)) bus ();

  reg_bank_arbiter #(.NUM_REQ(2), .ADDR_W(4), .REG_W(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    idle_inputs();
    step();
    step();
    rstb = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rstb = 1'b0; ena = 1'b1; bus.bank_rdata = 8'h00;
    idle_inputs();
    #3;
    n_tests++; if (bus.ack !== 2'b00 || bus.err !== 2'b00) begin n_fail++; $display("FAIL reset_ack_err got ack=%b err=%b want 00 00", bus.ack, bus.err); end
    n_tests++; if (bus.bank_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_we_busy got we=%b busy=%b want 0 0", bus.bank_we, busy); end
    n_tests++; if (bus.rdata !== 8'h00 || bus.bank_addr !== 4'h0 || bus.bank_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", bus.rdata, bus.bank_addr, bus.bank_wdata); end
    step();
    rstb = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    bus.req = 2'b01; bus.wr = 2'b01; bus.addr = 8'h03; bus.wdata = 16'h00A5;
    step();
    bus.req = '0; bus.wdata = 16'h00FF;
    n_tests++; if (bus.bank_we !== 1'b1 || bus.bank_addr !== 4'h3 || bus.bank_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_access got we=%b addr=%h wdata=%h want 1 3 a5", bus.bank_we, bus.bank_addr, bus.bank_wdata); end
    n_tests++; if (busy !== 1'b1 || bus.ack !== 2'b00) begin n_fail++; $display("FAIL wr_access_busy got busy=%b ack=%b want 1 00", busy, bus.ack); end
    step();
    n_tests++; if (bus.bank_we !== 1'b0 || bus.ack !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_resp got we=%b ack=%b busy=%b want 0 00 1", bus.bank_we, bus.ack, busy); end
    step();
    n_tests++; if (bus.ack !== 2'b01 || bus.err !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_ack got ack=%b err=%b busy=%b want 01 00 0", bus.ack, bus.err, busy); end
    n_tests++; if (bus.bank_addr !== 4'h3 || bus.bank_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_hold got addr=%h wdata=%h want 3 a5", bus.bank_addr, bus.bank_wdata); end
    step();
    n_tests++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL wr_ack_pulse got ack=%b want 00", bus.ack); end
  endtask

  task automatic test_read();
    idle_inputs();
    bus.req = 2'b10; bus.addr = 8'h90; bus.bank_rdata = 8'h5C;
    step();
    bus.req = '0;
    n_tests++; if (bus.bank_we !== 1'b0 || bus.bank_addr !== 4'h9) begin n_fail++; $display("FAIL rd_access got we=%b addr=%h want 0 9", bus.bank_we, bus.bank_addr); end
    step();
    n_tests++; if (bus.bank_we !== 1'b0 || bus.ack !== 2'b00) begin n_fail++; $display("FAIL rd_resp got we=%b ack=%b want 0 00", bus.bank_we, bus.ack); end
    step();
    n_tests++; if (bus.ack !== 2'b10 || bus.rdata !== 8'h5C || bus.err !== 2'b00) begin n_fail++; $display("FAIL rd_ack got ack=%b rdata=%h err=%b want 10 5c 00", bus.ack, bus.rdata, bus.err); end
    step();
  endtask

  task automatic test_status_write();
    idle_inputs();
    bus.req = 2'b01; bus.wr = 2'b01; bus.addr = 8'h0C; bus.wdata = 16'h0033; bus.bank_rdata = 8'h11;
    step();
    bus.req = '0;
    n_tests++; if (bus.bank_we !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL st_access got we=%b busy=%b want 0 1", bus.bank_we, busy); end
    step();
    n_tests++; if (bus.bank_we !== 1'b0) begin n_fail++; $display("FAIL st_resp got we=%b want 0", bus.bank_we); end
    step();
    n_tests++; if (bus.ack !== 2'b01 || bus.err !== 2'b01) begin n_fail++; $display("FAIL st_ack_err got ack=%b err=%b want 01 01", bus.ack, bus.err); end
    n_tests++; if (bus.rdata !== 8'h5C) begin n_fail++; $display("FAIL st_rdata_hold got %h want 5c", bus.rdata); end
    step();
    n_tests++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL st_err_pulse got %b want 00", bus.err); end
  endtask

  // Both requesters held from reset: acks land on cycles 3, 6, 9, 12.
  task automatic test_back_to_back();
    logic [1:0] exp;
    do_reset();
    bus.req = 2'b11; bus.wr = 2'b00; bus.addr = 8'h21;
    for (int c = 1; c <= 13; c++) begin
      step();
      exp = 2'b00;
`ifdef REG_ARB_FIXED_PRIO_EN
      if (c == 3 || c == 6 || c == 9 || c == 12) exp = 2'b01;
`else
      if (c == 3 || c == 9) exp = 2'b01;
      if (c == 6 || c == 12) exp = 2'b10;
`endif
      n_tests++; if (bus.ack !== exp) begin n_fail++; $display("FAIL b2b_ack cycle %0d got %b want %b", c, bus.ack, exp); end
    end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_ena_low();
    int seen;
    seen = 0;
    ena = 1'b0;
    bus.req = 2'b01; bus.wr = 2'b00; bus.addr = 8'h05;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.ack !== 2'b00 || busy !== 1'b0) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL ena_low_no_grant got %0d active cycles want 0", seen); end
    ena = 1'b1;
    step();
    bus.req = '0;
    n_tests++; if (busy !== 1'b1 || bus.ack !== 2'b00) begin n_fail++; $display("FAIL ena_grant got busy=%b ack=%b want 1 00", busy, bus.ack); end
    step();
    step();
    n_tests++; if (bus.ack !== 2'b01) begin n_fail++; $display("FAIL ena_ack got %b want 01", bus.ack); end
    step();
  endtask

  // ena falls during ACCESS of a config write, then of a status write: both acked, no err.
  task automatic test_ena_drop();
    logic [7:0] addrs [2];
    addrs[0] = 8'h03; addrs[1] = 8'h0C;
    for (int t = 0; t < 2; t++) begin
      ena = 1'b1;
      bus.req = 2'b01; bus.wr = 2'b01; bus.addr = addrs[t]; bus.wdata = 16'h0077;
      step();
      bus.req = '0;
      ena = 1'b0;
      #1;
      n_tests++; if (bus.bank_we !== 1'b0) begin n_fail++; $display("FAIL drop_we case %0d got %b want 0", t, bus.bank_we); end
      step();
      step();
      n_tests++; if (bus.ack !== 2'b01 || bus.err !== 2'b00) begin n_fail++; $display("FAIL drop_ack case %0d got ack=%b err=%b want 01 00", t, bus.ack, bus.err); end
      step();
    end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    bus.req = 2'b01; bus.wr = 2'b01; bus.addr = 8'h03; bus.wdata = 16'h0042;
    step();
    n_tests++; if (bus.bank_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got we=%b want 1", bus.bank_we); end
    rstb = 1'b0;
    #1;
    n_tests++; if (bus.bank_we !== 1'b0 || busy !== 1'b0 || bus.bank_addr !== 4'h0) begin n_fail++; $display("FAIL rstmid_now got we=%b busy=%b addr=%h want 0 0 0", bus.bank_we, busy, bus.bank_addr); end
    bus.req = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.ack !== 2'b00) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_ack got %0d ack cycles want 0", seen); end
    bus.req = 2'b10; bus.wr = 2'b00; bus.addr = 8'h70;
    rstb = 1'b1;
    step();
    bus.req = '0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got busy=%b want 1", busy); end
    step();
    step();
    n_tests++; if (bus.ack !== 2'b10) begin n_fail++; $display("FAIL rstmid_ack got %b want 10", bus.ack); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_status_write();
    test_back_to_back();
    test_ena_low();
    test_ena_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares the single config/status register-bank access port between NUM_REQ requesters, e.g. the SPI peripheral and an on-chip sequencer.
- Arbitrates round-robin and latches the winning request.
- Drives a one-cycle bank access, then returns read data plus a one-cycle ack to the winner.
- Sits between the requesters and the register bank (config write port, muxed read data).

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 4, bank address width; addr MSB=0 selects config half, MSB=1 selects status half
- REG_W, 8, register data width

Ports:
- clk  input  1  system clock
- rstb  input  1  asynchronous active-low reset
- ena  input  1  block enable; new grants only while high
- req  input  NUM_REQ  per-requester access request (level)
- wr  input  NUM_REQ  per-requester 1=write, 0=read
- addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  input  NUM_REQ*REG_W  packed write data; requester i at [i*REG_W +: REG_W]
- ack  output  NUM_REQ  one-cycle completion pulse, one-hot
- err  output  NUM_REQ  one-cycle pulse with ack when a write targeted the status half
- rdata  output  REG_W  read data, valid in the ack cycle
- bank_we  output  1  bank write enable, one cycle
- bank_addr  output  ADDR_W  bank address
- bank_wdata  output  REG_W  bank write data
- bank_rdata  input  REG_W  combinational bank read data for bank_addr
- busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset: state=IDLE; ack, err, bank_we, busy all 0; rdata, bank_addr, bank_wdata = 0; last_winner = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ACCESS, RESP. One access at a time, no pipelining.
- IDLE:
  - If ena and any req bit is set: choose the first set req scanning from last_winner+1 upward with modulo NUM_REQ wrap.
  - Latch winner index, wr, addr and wdata of the winner; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - bank_addr = latched addr.
  - bank_wdata = latched wdata.
  - bank_we = latched wr AND addr MSB==0.
  - Next state: RESP.
- RESP (1 cycle):
  - rdata <= bank_rdata for reads. rdata holds its previous value for writes.
  - ack[winner]=1.
  - err[winner]=1 if latched wr and addr MSB==1; such a write is never issued to the bank.
  - last_winner <= winner; go to IDLE.
- Latency and throughput:
  - Latency is req sampled at edge N, ack visible after edge N+2.
  - Back-to-back accesses from different requesters are spaced 3 cycles.
  - A requester holding req after its ack is re-arbitrated normally and loses to any other pending requester.
- Requests are sampled only in IDLE. Changing or dropping req, addr, wdata or wr after sampling has no effect; the latched access completes and is acked.
- ena low:
  - No new grant.
  - An access already in ACCESS or RESP completes.
  - bank_we is never asserted while ena is low at the ACCESS cycle; in that case the write is dropped and still acked, err=0.
- bank_addr and bank_wdata hold their last value outside ACCESS; bank_we is 0 outside ACCESS.
- Asynchronous reset mid-access: the access is aborted, no ack is issued, and all outputs return to reset values immediately.
- Only one ack bit and at most one err bit are set in any cycle.

Optional Feature:
- Macro: REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last_winner is unused and may be removed.
- Undefined (default): round-robin as above.
- All timing and other rules are identical in both builds.

Test Plan:
- Single write: req[0]=1, wr[0]=1, addr0=0x3, wdata0=0xA5 -> bank_we=1 with bank_addr=0x3, bank_wdata=0xA5 exactly one cycle later; ack[0] pulses 2 cycles after sampling; err=0.
- Read: req[1]=1, wr[1]=0, addr1=0x9, bank_rdata=0x5C -> bank_we stays 0; rdata=0x5C and ack[1]=1 in the same cycle.
- Contention, both req held continuously after reset -> ack order 0,1,0,1, each 3 cycles apart. With REG_ARB_FIXED_PRIO_EN the order is 0,0,0,...
- Write to status half: wr[0]=1, addr0=0xC -> bank_we never asserted; ack[0]=1 and err[0]=1 together.
- ena=0 with req[0]=1 -> no ack for 10 cycles; raise ena -> ack[0] 2 cycles after the first sampling edge.
- Assert rstb=0 during ACCESS -> no ack; bank_we=0 and busy=0 immediately. After release, req[1] alone -> ack[1] after 2 cycles.
